matrix_digit_scheduler: RTL
===========================

# matrix_digit_scheduler

Scan-rate generator and round-robin display arbiter for the 8x8 LED matrix digit driver. It produces the driver's column-advance enable and shares the single 4-bit digit input between two requesters, A and B. Each accepted digit is shown for a fixed number of whole frames. Digit changes happen only at the point where the driver samples its digit input, so no frame ever mixes two glyphs.

## Interface
- SCAN_DIV, 16: CLK cycles per column step; valid values are 2 or more.
- DWELL_FRAMES, 4: whole frames each granted digit is displayed; valid values are 1 or more.
- IDLE_DIGIT, 4'h0: digit presented when no request is being shown.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- a_valid  in  1  requester A holds a digit; must stay high, with a_data stable, until a_ready.
- a_data  in  4  requester A digit.
- a_ready  out  1  one-cycle grant/accept pulse to A.
- b_valid, b_data, b_ready: same as A, for requester B.
- scan_ce  out  1  column-advance enable; connects to the driver CE.
- col_idx  out  3  mirror of the driver column counter.
- digit_out  out  4  connects to the driver data input.
- frame_tick  out  1  pulse on the column 7→0 step.
- owner  out  1  source of the shown digit: 0 = A, 1 = B.
- showing  out  1  high when a granted digit is being shown.

## Operation
- Prescaler runs 0..SCAN_DIV-1 and wraps.
  - scan_ce is high for exactly the cycle where prescaler == SCAN_DIV-1.
- col_idx increments on scan_ce and wraps from 7 to 0.
  - frame_tick = scan_ce && col_idx==7.
- The driver and this block share RST and CE, so col_idx always equals the driver's column counter.
- Load point = scan_ce && col_idx==6.
  - digit_out updates only on the edge that ends a load-point cycle.
  - The value is therefore stable for all of column 7, when the driver latches it, and is displayed from the following column 0.
- FSM has two states, IDLE and SHOW, plus a dwell counter and a round-robin pointer `last`.
- At a load point, when in IDLE, or in SHOW with dwell==0, arbitrate:
  - Only one valid: grant it.
  - Both valid: grant the source that is not `last`.
  - On a grant: the matching ready is high in that cycle (combinational: load point & grant & valid). Then digit_out takes the granted data, owner takes the source, `last` takes the source, dwell = DWELL_FRAMES-1, and state becomes SHOW.
  - No valid: state becomes IDLE, digit_out = IDLE_DIGIT, showing = 0. owner holds its value.
- At a load point in SHOW with dwell>0: decrement dwell; no grant.
- Result: every granted digit occupies exactly DWELL_FRAMES frames (column 0 through column 7). With both sources always valid there are no idle frames.
- ready is never high outside a load point and never high without the matching valid. A and B are never both ready in the same cycle.
- Requests arriving while a digit is being shown wait. They are not queued beyond the requester's own valid.

## Timing
- Reset values, applied asynchronously:
  - prescaler 0, col_idx 0, scan_ce 0, frame_tick 0.
  - digit_out IDLE_DIGIT, owner 0, showing 0, a_ready 0, b_ready 0.
  - state IDLE, dwell 0, `last` = B (so A wins the first tie).
- Cycle numbering starts at the first CLK edge after RST falls (cycle 0).
  - scan_ce is high at cycles kS-1 for k ≥ 1, where S = SCAN_DIV.
  - First load point at 7S-1; later load points every 8S cycles.
  - frame_tick at 8S-1, 16S-1, and so on.
- Grant to digit_out latency: 1 cycle (the edge that ends the load-point cycle).
- Valid to ready latency: up to 8S·DWELL_FRAMES + 7S cycles, worst case.
- RST asserted mid-frame or mid-dwell: all outputs return to reset values immediately. Pending requests are not acknowledged.

## Test plan
- Reset, SCAN_DIV=4:
  - scan_ce at cycles 3, 7, …, 31; col_idx 0→7 then wraps to 0 at the cycle-31 edge.
  - frame_tick only at cycle 31; digit_out stays 0 with no valids.
- SCAN_DIV=4, DWELL=2, a_valid=1, a_data=5 from cycle 0, dropped after ready:
  - a_ready only at cycle 27; digit_out=5, owner=0, showing=1 from cycle 28.
  - At the cycle-91 edge: digit_out=0, showing=0.
- Both valid continuously (A=3, B=9), DWELL=1:
  - Grants alternate A,B,A,B at consecutive load points, A first.
  - digit_out sequence 3,9,3,9 changes every 32 cycles; never both ready in one cycle.
- A showing with DWELL=3; b_valid raised at cycle 30:
  - b_ready not before cycle 27+96=123; granted at 123; owner=1 from 124.
- RST pulsed at cycle 60 during SHOW:
  - All outputs reach reset values within the RST-high cycle.
  - After release, the first load point is again 7S-1 cycles later.
- SCAN_DIV=2, DWELL=1, a_valid held:
  - Load points at cycles 13, 29, 45; a_ready pulses at each; digit_out never shows IDLE_DIGIT after cycle 14.

Source files
------------

// File: rtl/matrix_digit_scheduler.sv
// Scan-rate prescaler, column mirror and round-robin A/B digit arbiter for the
// 8x8 LED matrix driver. Digit changes land only on column-6 load points.
module matrix_digit_scheduler #(
  parameter int          SCAN_DIV     = 16,
  parameter int          DWELL_FRAMES = 4,
  parameter logic [3:0]  IDLE_DIGIT   = 4'h0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       a_valid,
  input  logic [3:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_data,
  output logic       b_ready,
  output logic       scan_ce,
  output logic [2:0] col_idx,
  output logic [3:0] digit_out,
  output logic       frame_tick,
  output logic       owner,
  output logic       showing
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    digit_q, digit_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;   // 0 = A, 1 = B
  state_t        state_q, state_d;

  logic load, arb, grant_a, grant_b;

  assign scan_ce    = (pre_q == PRE_MAX);
  assign frame_tick = scan_ce && (col_q == 3'd7);
  // Load on column 6 so the new digit is stable throughout column 7, when the driver latches it.
  assign load       = scan_ce && (col_q == 3'd6);
  assign arb        = load && ((state_q == IDLE) || (dwell_q == '0));
  assign grant_a    = arb && a_valid && (!b_valid || last_q);
  assign grant_b    = arb && b_valid && (!a_valid || !last_q);

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign col_idx   = col_q;
  assign digit_out = digit_q;
  assign owner     = owner_q;
  assign showing   = (state_q == SHOW);

  always_comb begin
    pre_d   = scan_ce ? '0 : pre_q + 1'b1;
    col_d   = scan_ce ? col_q + 3'd1 : col_q;
    dwell_d = dwell_q;
    digit_d = digit_q;
    owner_d = owner_q;
    last_d  = last_q;
    state_d = state_q;
    if (arb) begin
      if (grant_a || grant_b) begin
        digit_d = grant_a ? a_data : b_data;
        owner_d = grant_b;
        last_d  = grant_b;
        dwell_d = DWELL_MAX;
        state_d = SHOW;
      end else begin
        digit_d = IDLE_DIGIT;
        state_d = IDLE;
      end
    end else if (load && state_q == SHOW) begin
      dwell_d = dwell_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q   <= '0;
      col_q   <= '0;
      dwell_q <= '0;
      digit_q <= IDLE_DIGIT;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      state_q <= IDLE;
    end else begin
      pre_q   <= pre_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      digit_q <= digit_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      state_q <= state_d;
    end
  end

endmodule
